// File: rtl/stim_check_pkg.sv
// Shared types and constants for the stimulus/check controller.
// Holds the FSM state encoding, the LFSR feedback tap mask and the substitute for a zero seed.
package stim_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Taps for x^16+x^14+x^13+x^11+1 with the register shifting toward bit 0
  localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;
  localparam logic [15:0] LFSR_ZERO_SUB = 16'h0001;

  function automatic logic [15:0] lfsr_seed_fix(input logic [15:0] seed);
    return (seed == 16'h0000) ? LFSR_ZERO_SUB : seed;
  endfunction

endpackage

// File: rtl/stim_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous seed load; the new bit enters at bit 15.
// Load and advance take one cycle; state is frozen while en is low.
module stim_lfsr16
  import stim_check_pkg::*;
#(
  parameter logic [15:0] RESET_SEED = 16'h0001
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= RESET_SEED;
    end else if (load) begin
      state <= seed;
    end else if (en) begin
      state <= {^(state & LFSR_TAP_MASK), state[15:1]};
    end
  end

endmodule

// File: rtl/stim_check_ctrl.sv
// Drives LFSR stimulus to a DUT and reference model, counts output mismatches; a run starts one cycle after start.
// hold stalls stimulus and sampling; with STIM_CHECK_WDOG_EN a long stall ends the run with timeout set.
module stim_check_ctrl #(
  parameter int          N_SAMPLES = 100,
  parameter int          CNT_W     = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          WDOG_CYC  = 1000
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             hold,
  output logic             din,
  input  logic             out_ref,
  input  logic             out_dut,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] errors,
  output logic [CNT_W-1:0] samples,
  output logic [CNT_W-1:0] first_err,
  output logic             first_err_vld,
  output logic             timeout
);
  import stim_check_pkg::*;

  localparam logic [15:0]      SEED_EFF = lfsr_seed_fix(LFSR_SEED);
  localparam logic [CNT_W-1:0] N_LAST   = CNT_W'(N_SAMPLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state_q, state_d;
  logic [15:0]      lfsr_q;
  logic             armed_q;
  logic [CNT_W-1:0] errors_q, samples_q, first_err_q;
  logic             first_vld_q;
  logic             accept, last_hit, sample, mismatch, wdog_fire;
  logic             unused_lfsr_hi;

  assign accept   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_hit = (samples_q == N_LAST);
  assign sample   = (state_q == ST_RUN) && !hold && !last_hit;
  assign mismatch = sample && (out_ref != out_dut);

  stim_lfsr16 #(
    .RESET_SEED(SEED_EFF)
  ) u_lfsr (
    .clk   (clk),
    .resetn(resetn),
    .load  (accept),
    .en    (sample),
    .seed  (SEED_EFF),
    .state (lfsr_q)
  );

  // din is forced low from reset until the first run loads the seed
  assign din            = lfsr_q[0] & armed_q;
  assign unused_lfsr_hi = ^lfsr_q[15:1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last_hit || wdog_fire) state_d = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      armed_q     <= 1'b0;
      errors_q    <= '0;
      samples_q   <= '0;
      first_err_q <= '0;
      first_vld_q <= 1'b0;
    end else if (accept) begin
      armed_q     <= 1'b1;
      errors_q    <= '0;
      samples_q   <= '0;
      first_err_q <= '0;
      first_vld_q <= 1'b0;
    end else if (sample) begin
      samples_q <= samples_q + CNT_W'(1);
      if (mismatch) begin
        errors_q <= (errors_q == CNT_MAX) ? errors_q : errors_q + CNT_W'(1);
        if (!first_vld_q) begin
          first_err_q <= samples_q;
          first_vld_q <= 1'b1;
        end
      end
    end
  end

`ifdef STIM_CHECK_WDOG_EN
  localparam int             WD_W    = $clog2(WDOG_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYC - 1);

  logic [WD_W-1:0] wdog_q;
  logic            timeout_q;

  // Fires on the WDOG_CYC-th consecutive held RUN cycle
  assign wdog_fire = (state_q == ST_RUN) && hold && !last_hit && (wdog_q == WD_LAST);
  assign timeout   = timeout_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else if (accept) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else if ((state_q == ST_RUN) && hold) begin
      wdog_q <= wdog_q + WD_W'(1);
      if (wdog_fire) timeout_q <= 1'b1;
    end else begin
      wdog_q <= '0;
    end
  end
`else
  logic unused_wdog_cfg;

  assign wdog_fire       = 1'b0;
  assign timeout         = 1'b0;
  assign unused_wdog_cfg = (WDOG_CYC != 0);
`endif

  assign errors        = errors_q;
  assign samples       = samples_q;
  assign first_err     = first_err_q;
  assign first_err_vld = first_vld_q;

endmodule
